// File: rtl/systolic_matmul_n.sv
// N x N output-stationary systolic matrix multiplier: C = A * B with run-time
// signed/unsigned operands and saturating or truncating OW-bit results.
module systolic_matmul_n #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 8,
    parameter int AW = 2 * DW + $clog2(N)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic                SIGNED,
    input  logic                SAT,
    input  logic [N*N*DW-1:0]   A_IN,
    input  logic [N*N*DW-1:0]   B_IN,
    output logic                BUSY,
    output logic                DONE,
    output logic [N*N*OW-1:0]   C_OUT
);

    localparam int KW = $clog2(3 * N);
    localparam logic [KW-1:0] K_LAST = KW'(3 * N - 3);
    localparam logic [AW-1:0] U_MAX = {{(AW - OW){1'b0}}, {OW{1'b1}}};
    localparam logic [AW-1:0] S_MAX = {{(AW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic [AW-1:0] S_MIN = {{(AW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FEED = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_r, state_next_s;
    logic [KW-1:0]       k_r;
    logic [N*N*DW-1:0]   a_lat_r, b_lat_r;
    logic                signed_r, sat_r;
    logic [DW-1:0]       a_pipe_r [N][N];
    logic [DW-1:0]       b_pipe_r [N][N];
    logic [DW-1:0]       a_in_s   [N][N];
    logic [DW-1:0]       b_in_s   [N][N];
    logic [AW-1:0]       acc_r    [N][N];
    logic [N*N*OW-1:0]   c_out_r;
    logic                busy_r, done_r;

    // Modulo-2^AW multiply-accumulate; the true sum always fits AW bits in the
    // selected interpretation, so wrap-around on intermediate terms is harmless.
    function automatic logic [AW-1:0] mac(input logic [AW-1:0] acc,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic          sgn);
        logic signed [DW:0]     ea;
        logic signed [DW:0]     eb;
        logic signed [2*DW+1:0] prod;
        ea   = $signed({sgn & a[DW-1], a});
        eb   = $signed({sgn & b[DW-1], b});
        prod = ea * eb;
        return acc + AW'(prod);
    endfunction

    function automatic logic [OW-1:0] to_out(input logic [AW-1:0] acc,
                                             input logic          sgn,
                                             input logic          sat);
        logic [OW-1:0] res;
        if (!sat) begin
            res = acc[OW-1:0];
        end else if (sgn) begin
            if ($signed(acc) > $signed(S_MAX)) begin
                res = {1'b0, {(OW - 1){1'b1}}};
            end else if ($signed(acc) < $signed(S_MIN)) begin
                res = {1'b1, {(OW - 1){1'b0}}};
            end else begin
                res = acc[OW-1:0];
            end
        end else begin
            if (acc > U_MAX) begin
                res = {OW{1'b1}};
            end else begin
                res = acc[OW-1:0];
            end
        end
        return res;
    endfunction

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = START ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_next_s = ST_FEED;
            ST_FEED: state_next_s = (k_r == K_LAST) ? ST_OUT : ST_FEED;
            ST_OUT:  state_next_s = ST_DONE;
            ST_DONE: state_next_s = START ? ST_LOAD : ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, skew counter and registered status outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            k_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            k_r     <= (state_r == ST_FEED) ? k_r + KW'(1) : '0;
            busy_r  <= (state_next_s == ST_LOAD) || (state_next_s == ST_FEED) ||
                       (state_next_s == ST_OUT);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand and mode capture on an accepted START
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_lat_r  <= '0;
            b_lat_r  <= '0;
            signed_r <= 1'b0;
            sat_r    <= 1'b0;
        end else if (START && (state_r == ST_IDLE || state_r == ST_DONE)) begin
            a_lat_r  <= A_IN;
            b_lat_r  <= B_IN;
            signed_r <= SIGNED;
            sat_r    <= SAT;
        end else begin
            a_lat_r  <= a_lat_r;
            b_lat_r  <= b_lat_r;
            signed_r <= signed_r;
            sat_r    <= sat_r;
        end
    end

    // Skewed edge injection: row i lags by i cycles, column j by j cycles
    always_comb begin
        int m;
        m = 0;
        for (int i = 0; i < N; i++) begin
            m = int'(k_r) - i;
            if (m >= 0 && m < N) begin
                a_in_s[i][0] = a_lat_r[(i * N + m) * DW +: DW];
            end else begin
                a_in_s[i][0] = '0;
            end
            for (int j = 1; j < N; j++) begin
                a_in_s[i][j] = a_pipe_r[i][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            m = int'(k_r) - j;
            if (m >= 0 && m < N) begin
                b_in_s[0][j] = b_lat_r[(m * N + j) * DW +: DW];
            end else begin
                b_in_s[0][j] = '0;
            end
            for (int i = 1; i < N; i++) begin
                b_in_s[i][j] = b_pipe_r[i-1][j];
            end
        end
    end

    // PE array: forward operands east/south and accumulate their product
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (RESET || state_r == ST_LOAD) begin
                    acc_r[i][j]    <= '0;
                    a_pipe_r[i][j] <= '0;
                    b_pipe_r[i][j] <= '0;
                end else if (state_r == ST_FEED) begin
                    acc_r[i][j]    <= mac(acc_r[i][j], a_in_s[i][j], b_in_s[i][j], signed_r);
                    a_pipe_r[i][j] <= a_in_s[i][j];
                    b_pipe_r[i][j] <= b_in_s[i][j];
                end else begin
                    acc_r[i][j]    <= acc_r[i][j];
                    a_pipe_r[i][j] <= a_pipe_r[i][j];
                    b_pipe_r[i][j] <= b_pipe_r[i][j];
                end
            end
        end
    end

    // Result conversion, held until the next operation reaches OUT
    always_ff @(posedge CLK) begin
        if (RESET) begin
            c_out_r <= '0;
        end else if (state_r == ST_OUT) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    c_out_r[(i * N + j) * OW +: OW] <= to_out(acc_r[i][j], signed_r, sat_r);
                end
            end
        end else begin
            c_out_r <= c_out_r;
        end
    end

    assign BUSY  = busy_r;
    assign DONE  = done_r;
    assign C_OUT = c_out_r;

endmodule

// File: tb/tb_systolic_matmul_n.sv
// Self-checking bench for systolic_matmul_n: N=3 and N=4 instances checked
// against a plain matrix-product reference model.
module tb_systolic_matmul_n;

    logic         clk;
    logic         rst;
    logic         st3, sg3, sa3, busy3, done3;
    logic [71:0]  a3, b3, c3;
    logic         st4, sg4, sa4, busy4, done4;
    logic [127:0] a4, b4, c4;

    int am [16];
    int bm [16];
    int n_checks = 0;
    int n_fail   = 0;

    systolic_matmul_n #(.N(3), .DW(8), .OW(8)) d3 (
        .CLK(clk), .RESET(rst), .START(st3), .SIGNED(sg3), .SAT(sa3),
        .A_IN(a3), .B_IN(b3), .BUSY(busy3), .DONE(done3), .C_OUT(c3)
    );

    systolic_matmul_n #(.N(4), .DW(8), .OW(8)) d4 (
        .CLK(clk), .RESET(rst), .START(st4), .SIGNED(sg4), .SAT(sa4),
        .A_IN(a4), .B_IN(b4), .BUSY(busy4), .DONE(done4), .C_OUT(c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pack(input int n, input bit use_b);
        logic [127:0] r;
        int v;
        r = '0;
        for (int idx = 0; idx < n * n; idx++) begin
            v = use_b ? bm[idx] : am[idx];
            r[idx*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j] in full precision, then convert
    function automatic logic [127:0] model(input int n, input logic sgn, input logic sat);
        logic [127:0] r;
        longint s;
        longint va, vb;
        r = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    va = am[i*n+k];
                    vb = bm[k*n+j];
                    if (sgn && va > 127) va = va - 256;
                    if (sgn && vb > 127) vb = vb - 256;
                    s = s + va * vb;
                end
                if (sat && sgn) begin
                    if (s > 127) s = 127;
                    else if (s < -128) s = -128;
                end else if (sat) begin
                    if (s > 255) s = 255;
                end
                r[(i*n+j)*8 +: 8] = s[7:0];
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int n, output logic d, output logic b, output logic [127:0] c);
        if (n == 3) begin
            d = done3; b = busy3; c = {56'd0, c3};
        end else begin
            d = done4; b = busy4; c = c4;
        end
    endtask

    // Called at a negedge; START is sampled at the following posedge (edge 0)
    task automatic launch(input int n, input logic sgn, input logic sat, output logic [127:0] exp);
        logic [127:0] ta, tb;
        ta  = pack(n, 1'b0);
        tb  = pack(n, 1'b1);
        exp = model(n, sgn, sat);
        if (n == 3) begin
            a3 = ta[71:0]; b3 = tb[71:0]; sg3 = sgn; sa3 = sat; st3 = 1'b1;
        end else begin
            a4 = ta; b4 = tb; sg4 = sgn; sa4 = sat; st4 = 1'b1;
        end
        @(negedge clk);
        st3 = 1'b0;
        st4 = 1'b0;
    endtask

    // Entered mid cycle 1; returns mid DONE cycle
    task automatic wait_check(input int n, input string tag, input logic [127:0] exp);
        int cyc, bz;
        logic d, b;
        logic [127:0] c;
        cyc = 1;
        bz  = 0;
        sample(n, d, b, c);
        while (!d && cyc < 60) begin
            if (b) bz++;
            @(negedge clk);
            cyc++;
            sample(n, d, b, c);
        end
        check({tag, "_latency"}, 128'(cyc), 128'(3 * n + 1));
        check({tag, "_busy_cycles"}, 128'(bz), 128'(3 * n));
        check({tag, "_busy_in_done"}, 128'(b), 128'd0);
        check({tag, "_c"}, c, exp);
    endtask

    task automatic run(input int n, input string tag, input logic sgn, input logic sat);
        logic [127:0] exp, c;
        logic d, b;
        launch(n, sgn, sat, exp);
        wait_check(n, tag, exp);
        @(negedge clk);
        sample(n, d, b, c);
        check({tag, "_done_pulse"}, 128'(d), 128'd0);
        check({tag, "_c_hold"}, c, exp);
    endtask

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < 16; i++) begin
            am[i] = av;
            bm[i] = bv;
        end
    endtask

    initial begin
        logic [127:0] exp1, exp2, c;
        logic d, b;
        int pulses, first;
        rst = 1'b1;
        st3 = 1'b0; sg3 = 1'b0; sa3 = 1'b0; a3 = '0; b3 = '0;
        st4 = 1'b0; sg4 = 1'b0; sa4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy3", 128'(busy3), 128'd0);
        check("rst_done3", 128'(done3), 128'd0);
        check("rst_c3", {56'd0, c3}, 128'd0);
        check("rst_c4", c4, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Identity times 1..9
        for (int i = 0; i < 9; i++) begin
            am[i] = ((i / 3) == (i % 3)) ? 1 : 0;
            bm[i] = i + 1;
        end
        run(3, "ident", 1'b0, 1'b1);

        fill(255, 255);
        run(3, "u255_sat", 1'b0, 1'b1);
        run(3, "u255_trunc", 1'b0, 1'b0);
        fill(2, 253);
        run(3, "s2xm3_sat", 1'b1, 1'b1);
        run(3, "s2xm3_trunc", 1'b1, 1'b0);
        fill(128, 127);
        run(3, "sm128x127_sat", 1'b1, 1'b1);

        // Random operands and modes
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 9; i++) begin
                am[i] = int'($urandom_range(0, 255));
                bm[i] = int'($urandom_range(0, 255));
            end
            run(3, $sformatf("rand3_%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // START pulses while busy are ignored, operand changes have no effect
        for (int i = 0; i < 9; i++) begin
            am[i] = i + 3;
            bm[i] = 20 - i;
        end
        launch(3, 1'b0, 1'b0, exp1);
        pulses = 0;
        first  = 0;
        c      = '0;
        for (int cy = 1; cy <= 25; cy++) begin
            st3 = (cy == 3 || cy == 7);
            if (st3) a3 = 72'({$urandom(), $urandom(), $urandom()});
            if (done3) begin
                pulses++;
                if (first == 0) begin
                    first = cy;
                    c = {56'd0, c3};
                end
            end
            @(negedge clk);
        end
        st3 = 1'b0;
        check("busy_start_pulses", 128'(pulses), 128'd1);
        check("busy_start_cycle", 128'(first), 128'd10);
        check("busy_start_c", c, exp1);

        // Back-to-back: START held in the DONE cycle
        fill(1, 1);
        launch(3, 1'b0, 1'b1, exp1);
        wait_check(3, "b2b_first", exp1);
        for (int i = 0; i < 9; i++) begin
            am[i] = int'($urandom_range(0, 255));
            bm[i] = int'($urandom_range(0, 255));
        end
        launch(3, 1'b1, 1'b0, exp2);
        wait_check(3, "b2b_second", exp2);
        @(negedge clk);

        // Reset mid-FEED aborts the op
        fill(7, 9);
        launch(3, 1'b0, 1'b0, exp1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 128'(busy3), 128'd0);
        check("abort_done", 128'(done3), 128'd0);
        check("abort_c", {56'd0, c3}, 128'd0);
        pulses = 0;
        for (int cy = 0; cy < 15; cy++) begin
            if (done3) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", 128'(pulses), 128'd0);
        run(3, "after_abort", 1'b0, 1'b0);

        // N=4 instance
        fill(1, 1);
        run(4, "n4_ones", 1'b0, 1'b1);
        fill(255, 255);
        run(4, "n4_u255_trunc", 1'b0, 1'b0);
        run(4, "n4_u255_sat", 1'b0, 1'b1);
        fill(128, 128);
        run(4, "n4_sm128sq_trunc", 1'b1, 1'b0);
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 16; i++) begin
                am[i] = int'($urandom_range(0, 255));
                bm[i] = int'($urandom_range(0, 255));
            end
            run(4, $sformatf("rand4_%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        sample(4, d, b, c);
        check("n4_idle_busy", 128'(b), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
